uart_rx_byte: RTL and testbench

//   8N1 UART receiver feeding the pointer-placement stage, which assembles

---
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 tb/tb_uart_rx_byte.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a toggle handshake.
// Each good byte appears on data, and dataAvail inverts on the same edge.
// The consumer spots a new byte by comparing dataAvail with its own copy.
// A low stop bit raises a one-cycle frameErr. The receiver then ignores the
// line until it returns high, so a held break reports only one error.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] data,
  output logic       dataAvail,
  output logic       frameErr,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] clkCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shift;

  // Two-flop synchroniser. Both flops reset to the idle-high line level.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM. All outputs are registered, and busy follows the next state.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clkCnt    <= '0;
      bitIdx    <= '0;
      shift     <= '0;
      data      <= '0;
      dataAvail <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            clkCnt <= '0;
            busy   <= 1'b1;
          end
        end
        // Check the start bit again at mid-bit, so a short low glitch is rejected.
        START: begin
          if (clkCnt == HALF_M1) begin
            clkCnt <= '0;
            if (!rxs) begin
              state  <= DATA;
              bitIdx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        // From mid start bit, each full bit period lands on the middle of the next bit.
        DATA: begin
          if (clkCnt == FULL_M1) begin
            clkCnt        <= '0;
            shift[bitIdx] <= rxs;
            if (bitIdx == 3'd7) state <= STOP;
            else                bitIdx <= bitIdx + 1'b1;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        // Commit the byte only when framing is good. IDLE is entered at mid stop
        // bit, so a following start edge with no idle gap is still caught.
        STOP: begin
          if (clkCnt == FULL_M1) begin
            clkCnt <= '0;
            if (rxs) begin
              data      <= shift;
              dataAvail <= ~dataAvail;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              frameErr <= 1'b1;
              state    <= BRK;
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        // Wait for the line to go high before looking for a new start bit.
        BRK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte with CLKS_PER_BIT=16.
// Good frames push their byte to a scoreboard, and a negedge monitor collects
// the bytes on each dataAvail toggle. A small model of the pointer stage
// pairs bytes into a coordinate.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       CLOCK = 1'b0;
  logic       reset;
  logic       RX;
  logic [7:0] data;
  logic       dataAvail;
  logic       frameErr;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK(CLOCK), .reset(reset), .RX(RX),
    .data(data), .dataAvail(dataAvail), .frameErr(frameErr), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int cyc = 0, tog_cnt = 0, fe_cycles = 0, fe_pulses = 0, both_cnt = 0;
  int last_tog = 0, start_cyc = 0;
  logic prev_av = 1'b0, prev_fe = 1'b0;

  // Monitor: records each toggle with its byte, and frameErr activity.
  always @(negedge CLOCK) begin
    cyc++;
    if (reset) begin
      prev_av = dataAvail;
      prev_fe = 1'b0;
    end else begin
      if (dataAvail !== prev_av) begin
        obs_q.push_back(data);
        tog_cnt++;
        last_tog = cyc;
        if (frameErr === 1'b1) both_cnt++;
      end
      prev_av = dataAvail;
      if (frameErr === 1'b1) begin
        fe_cycles++;
        if (!prev_fe) fe_pulses++;
      end
      prev_fe = frameErr;
    end
  end

  // Pointer-stage model: the first byte of a pair is the low byte, the second the high byte.
  logic       cons_av, phase;
  logic [7:0] lo_b;
  logic [15:0] coord;
  int pairs = 0;
  always @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      cons_av <= 1'b0; phase <= 1'b0; lo_b <= 8'h00; coord <= 16'h0000; pairs <= 0;
    end else if (dataAvail != cons_av) begin
      cons_av <= dataAvail;
      phase   <= ~phase;
      if (phase) begin coord <= {data, lo_b}; pairs <= pairs + 1; end
      else lo_b <= data;
    end
  end

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge CLOCK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    RX = 1'b0;
    start_cyc = cyc;
    if (stopb) exp_q.push_back(b);
    repeat (CPB) @(posedge CLOCK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(posedge CLOCK);
    end
    RX = stopb;
    repeat (CPB) @(posedge CLOCK);
  endtask

  task automatic test_reset;
    reset = 1'b1; RX = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    n_chk++;
    if ({data, dataAvail, frameErr, busy} !== 11'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 000", {data, dataAvail, frameErr, busy});
    end
    @(negedge CLOCK); reset = 1'b0;
    idle(5); #1;
    n_chk++;
    if ({data, dataAvail, frameErr, busy} !== 11'h000) begin
      n_fail++; $display("FAIL post_reset_idle: got %h required 000", {data, dataAvail, frameErr, busy});
    end
  endtask

  task automatic test_two_frames;
    int t0, lat;
    send_byte(8'h55, 1'b1);
    t0 = start_cyc;
    idle(4); #1;
    lat = last_tog - t0 - 1;
    n_chk++;
    if (lat < 153 || lat > 155) begin
      n_fail++; $display("FAIL latency: got %0d cycles required 154+/-1", lat);
    end
    n_chk++;
    if (dataAvail !== 1'b1 || data !== 8'h55) begin
      n_fail++; $display("FAIL first_frame: got av=%b data=%h required av=1 data=55", dataAvail, data);
    end
    send_byte(8'hA3, 1'b1);
    idle(4); #1;
    n_chk++;
    if (dataAvail !== 1'b0 || data !== 8'hA3) begin
      n_fail++; $display("FAIL second_frame: got av=%b data=%h required av=0 data=a3", dataAvail, data);
    end
    n_chk++;
    if (fe_cycles !== 0) begin
      n_fail++; $display("FAIL two_frames_no_err: got %0d err cycles required 0", fe_cycles);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sb_two_frames: got no byte required %h", e);
      end else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sb_two_frames: got %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_glitch;
    int tc = tog_cnt;
    RX = 1'b0;
    repeat (CPB / 4) @(posedge CLOCK);
    #1;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_busy_high: got %b required 1", busy);
    end
    idle(2 * CPB); #1;
    n_chk++;
    if (busy !== 1'b0 || tog_cnt != tc || data !== 8'hA3 || dataAvail !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject: got busy=%b toggles=%0d data=%h required busy=0 toggles=%0d data=a3",
                         busy, tog_cnt - tc, data, 0);
    end
  endtask

  task automatic test_frame_error;
    int tc = tog_cnt;
    send_byte(8'h3C, 1'b0);
    RX = 1'b0;
    repeat (3 * CPB) @(posedge CLOCK);
    idle(CPB); #1;
    n_chk++;
    if (fe_pulses != 1 || fe_cycles != 1) begin
      n_fail++; $display("FAIL frame_err_pulse: got pulses=%0d cycles=%0d required 1 1", fe_pulses, fe_cycles);
    end
    n_chk++;
    if (tog_cnt != tc || data !== 8'hA3) begin
      n_fail++; $display("FAIL frame_err_no_byte: got toggles=%0d data=%h required 0 a3", tog_cnt - tc, data);
    end
    send_byte(8'h81, 1'b1);
    idle(4); #1;
    n_chk++;
    if (tog_cnt != tc + 1 || data !== 8'h81 || busy !== 1'b0) begin
      n_fail++; $display("FAIL after_break: got toggles=%0d data=%h busy=%b required 1 81 0", tog_cnt - tc, data, busy);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sb_frame_err: got no byte required %h", e);
      end else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sb_frame_err: got %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b = 8'hF0;
    RX = 1'b0;
    repeat (CPB) @(posedge CLOCK);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (CPB) @(posedge CLOCK);
    end
    RX = b[4];
    repeat (CPB / 2) @(posedge CLOCK);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (data !== 8'h00 || dataAvail !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got data=%h av=%b busy=%b required 00 0 0", data, dataAvail, busy);
    end
    RX = 1'b1;
    repeat (2) @(negedge CLOCK);
    reset = 1'b0;
    idle(2 * CPB);
    send_byte(8'h7E, 1'b1);
    idle(4); #1;
    n_chk++;
    if (data !== 8'h7E || dataAvail !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_frame: got data=%h av=%b required 7e 1", data, dataAvail);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sb_reset_mid: got no byte required %h", e);
      end else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sb_reset_mid: got %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int tc = tog_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4); #1;
    n_chk++;
    if (tog_cnt != tc + 2 || data !== 8'hFF) begin
      n_fail++; $display("FAIL back_to_back: got toggles=%0d data=%h required 2 ff", tog_cnt - tc, data);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sb_back_to_back: got no byte required %h", e);
      end else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sb_back_to_back: got %h required %h", o, e); end
      end
    end
  endtask

  task automatic test_pointer_pair;
    @(negedge CLOCK); reset = 1'b1;
    repeat (2) @(negedge CLOCK); reset = 1'b0;
    idle(CPB);
    send_byte(8'h90, 1'b1);
    send_byte(8'h01, 1'b1);
    idle(4); #1;
    n_chk++;
    if (coord !== 16'h0190 || pairs != 1) begin
      n_fail++; $display("FAIL pointer_pair: got coord=%h pairs=%0d required 0190 1", coord, pairs);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sb_pointer: got no byte required %h", e);
      end else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL sb_pointer: got %h required %h", o, e); end
      end
    end
    n_chk++;
    if (obs_q.size() != 0 || both_cnt != 0) begin
      n_fail++; $display("FAIL spurious_output: got extra=%0d err_with_toggle=%0d required 0 0", obs_q.size(), both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_pointer_pair();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
